pipe_adder: RTL

- Parametrised, pipelined, multi-bit add/subtract unit built as chained carry-propagating slices.
- Operands are split into STAGES chunks of WIDTH/STAGES bits. Each pipeline stage adds one chunk and registers the carry into the next stage.
- Uses a valid/ready handshake on both sides so it can sit between ALU operand fetch and writeback in the datapath.

---
 rtl/pipe_adder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract unit. Each of STAGES stages resolves one
// WIDTH/STAGES-bit chunk and hands its carry to the next stage through a register.
// Operands travel with the transaction (skew) and finished low chunks are carried
// along with it (de-skew), so the last stage holds the complete result.
module pipe_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned Chunk = WIDTH / STAGES;

   // Per-stage occupancy and handshake strobes
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] adv;

   // Per-stage payload: A and effective B travel whole, sum fills in chunk by chunk
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [STAGES-1:0] carry_q, carry_d;

   // Subtraction folds into addition: a + ~b + ~cin
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;

   // Handshake: resolve advance from the output backwards so bubbles collapse
   always_comb begin
      int prv;
      int nxt;
      adv      = '0;
      load     = '0;
      valid_d  = '0;
      in_ready = 1'b0;
      prv      = 0;
      nxt      = 0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         prv = (k > 0) ? k - 1 : 0;
         nxt = (k < int'(STAGES) - 1) ? k + 1 : k;
         if (k == int'(STAGES) - 1) begin
            adv[k] = valid_q[k] & out_ready;
         end else begin
            adv[k] = valid_q[k] & load[nxt];
         end
         if (k > 0) begin
            load[k] = valid_q[prv] & (~valid_q[k] | adv[k]);
         end
      end
      in_ready = ~valid_q[0] | adv[0];
      load[0]  = in_valid & in_ready;
      for (int k = 0; k < int'(STAGES); k++) begin
         valid_d[k] = load[k] | (valid_q[k] & ~adv[k]);
      end
   end

   // Datapath: each stage adds its own chunk on top of what the previous stage holds
   always_comb begin
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic             c_src;
      logic [Chunk:0]   part;
      int               prv;
      b_eff   = in_sub ? ~in_b : in_b;
      cin_eff = in_cin ^ in_sub;
      a_d     = '{default: '0};
      b_d     = '{default: '0};
      sum_d   = '{default: '0};
      carry_d = '0;
      a_src   = '0;
      b_src   = '0;
      s_src   = '0;
      c_src   = 1'b0;
      part    = '0;
      prv     = 0;
      for (int k = 0; k < int'(STAGES); k++) begin
         prv = (k > 0) ? k - 1 : 0;
         if (k == 0) begin
            a_src = in_a;
            b_src = b_eff;
            s_src = '0;
            c_src = cin_eff;
         end else begin
            a_src = a_q[prv];
            b_src = b_q[prv];
            s_src = sum_q[prv];
            c_src = carry_q[prv];
         end
         part = {1'b0, a_src[k*Chunk +: Chunk]} + {1'b0, b_src[k*Chunk +: Chunk]}
              + {{Chunk{1'b0}}, c_src};
         a_d[k]                      = a_src;
         b_d[k]                      = b_src;
         sum_d[k]                    = s_src;
         sum_d[k][k*Chunk +: Chunk]  = part[Chunk-1:0];
         carry_d[k]                  = part[Chunk];
      end
   end

   // Stage registers: payload only moves on load, so a stalled output holds steady
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < int'(STAGES); k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < int'(STAGES); k++) begin
            if (load[k]) begin
               a_q[k]     <= a_d[k];
               b_q[k]     <= b_d[k];
               sum_q[k]   <= sum_d[k];
               carry_q[k] <= carry_d[k];
            end
         end
      end
   end

   // Result flags derive from the last stage's registered contents
   always_comb begin
      out_valid = valid_q[STAGES-1];
      out_sum   = sum_q[STAGES-1];
      out_cout  = carry_q[STAGES-1];
      out_ovf   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                & (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
      out_zero  = (sum_q[STAGES-1] == '0);
   end

endmodule
